// File: rtl/kernel_load_ctrl.sv
// rtl/kernel_load_ctrl.sv - 3x3 kernel coefficient loader with frame-synchronous shadow-to-active swap.
// Optional tap-reversal (convolution order) enabled by defining KERNEL_FLIP_EN.
module kernel_load_ctrl #(
    parameter int COEF_W     = 17,
    parameter int CENTER_RST = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_start,
    input  logic                   flip,
    input  logic                   coef_valid,
    input  logic [COEF_W-1:0]      coef_data,
    output logic                   coef_ready,
    input  logic                   frame_start,
    output logic [8:0][COEF_W-1:0] kernel_out,
    output logic                   kernel_update,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    localparam logic [COEF_W-1:0]      CENTER     = COEF_W'(CENTER_RST);
    localparam logic [8:0][COEF_W-1:0] KERNEL_RST =
        {{(4*COEF_W){1'b0}}, CENTER, {(4*COEF_W){1'b0}}};

    state_t                   state;
    logic [3:0]               idx;
    logic                     flip_q;
    logic [8:0][COEF_W-1:0]   shadow;
    logic [3:0]               wr_idx;
    logic                     flip_next;

`ifdef KERNEL_FLIP_EN
    assign flip_next = flip;
    assign wr_idx    = flip_q ? (4'd8 - idx) : idx;
`else
    // Correlation order only: flip is never captured and no reverse index exists.
    logic unused_flip;
    assign unused_flip = flip ^ flip_q;
    assign flip_next   = 1'b0;
    assign wr_idx      = idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= 4'd0;
            flip_q        <= 1'b0;
            coef_ready    <= 1'b0;
            kernel_update <= 1'b0;
            busy          <= 1'b0;
            shadow        <= KERNEL_RST;
            kernel_out    <= KERNEL_RST;
        end else begin
            kernel_update <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        idx        <= 4'd0;
                        flip_q     <= flip_next;
                        coef_ready <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    // A restart wins over a coefficient presented in the same cycle.
                    if (load_start) begin
                        idx    <= 4'd0;
                        flip_q <= flip_next;
                    end else if (coef_valid && coef_ready) begin
                        shadow[wr_idx] <= coef_data;
                        if (idx == 4'd8) begin
                            state      <= ARMED;
                            coef_ready <= 1'b0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ARMED: begin
                    if (frame_start) begin
                        kernel_out    <= shadow;
                        kernel_update <= 1'b1;
                        if (load_start) begin
                            state      <= LOAD;
                            idx        <= 4'd0;
                            flip_q     <= flip_next;
                            coef_ready <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (load_start) begin
                        // Armed kernel is dropped; it will be overwritten by the new load.
                        state      <= LOAD;
                        idx        <= 4'd0;
                        flip_q     <= flip_next;
                        coef_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    idx        <= 4'd0;
                    coef_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// tb/tb_kernel_load_ctrl.sv - scoreboard bench for kernel_load_ctrl against a queue-based load model.
module tb_kernel_load_ctrl;

    localparam int W = 17;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 load_start = 1'b0;
    logic                 flip = 1'b0;
    logic                 coef_valid = 1'b0;
    logic [W-1:0]         coef_data = '0;
    logic                 coef_ready;
    logic                 frame_start = 1'b0;
    logic [8:0][W-1:0]    kernel_out;
    logic                 kernel_update;
    logic                 busy;

    kernel_load_ctrl #(.COEF_W(W), .CENTER_RST(256)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .flip(flip),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
        .frame_start(frame_start), .kernel_out(kernel_out),
        .kernel_update(kernel_update), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              ready;
        logic              busy;
        logic              upd;
        logic [8:0][W-1:0] k;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: a load in progress collects coefficients in a list;
    // a full list of nine is an armed kernel waiting for a frame boundary.
    bit                loading = 1'b0;
    logic [W-1:0]      got[$];
    bit                fq = 1'b0;
    logic [8:0][W-1:0] act;

    function automatic logic [8:0][W-1:0] reset_kernel();
        logic [8:0][W-1:0] r;
        for (int i = 0; i < 9; i++) r[i] = '0;
        r[4] = W'(256);
        return r;
    endfunction

    function automatic bit flip_sel(input bit f);
`ifdef KERNEL_FLIP_EN
        return f;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [W*9-1:0] actual, input logic [W*9-1:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, actual, required);
        end
    endtask

    task automatic cyc(input bit ls, input bit fl, input bit cv, input logic [W-1:0] cd, input bit fs);
        exp_t e;
        bit   upd = 1'b0;
        @(negedge clk);
        load_start  = ls;
        flip        = fl;
        coef_valid  = cv;
        coef_data   = cd;
        frame_start = fs;
        if (!loading) begin
            if (ls) begin
                loading = 1'b1;
                got.delete();
                fq = flip_sel(fl);
            end
        end else if (got.size() < 9) begin
            if (ls) begin
                got.delete();
                fq = flip_sel(fl);
            end else if (cv) begin
                got.push_back(cd);
            end
        end else begin
            if (fs) begin
                for (int i = 0; i < 9; i++) act[fq ? 8 - i : i] = got[i];
                upd = 1'b1;
                got.delete();
                if (ls) fq = flip_sel(fl);
                else loading = 1'b0;
            end else if (ls) begin
                got.delete();
                fq = flip_sel(fl);
            end
        end
        e.ready = loading && (got.size() < 9);
        e.busy  = loading;
        e.upd   = upd;
        e.k     = act;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_kernel"}, kernel_out, reset_kernel());
        check({tag, "_ready"}, {{(9*W-1){1'b0}}, coef_ready}, '0);
        check({tag, "_busy"}, {{(9*W-1){1'b0}}, busy}, '0);
        check({tag, "_update"}, {{(9*W-1){1'b0}}, kernel_update}, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        load_start = 1'b0; coef_valid = 1'b0; frame_start = 1'b0; flip = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        loading = 1'b0;
        got.delete();
        fq  = 1'b0;
        act = reset_kernel();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load9(input bit fl, input int base, input bit gaps);
        cyc(1'b1, fl, 1'b0, '0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (gaps && (i % 2 == 1)) cyc(1'b0, 1'b0, 1'b0, W'(999), 1'b0);
            cyc(1'b0, 1'b0, 1'b1, W'(base + i), 1'b0);
        end
    endtask

    // Monitor: pops one expectation per cycle the stimulus accounted for.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("coef_ready", {{(9*W-1){1'b0}}, coef_ready}, {{(9*W-1){1'b0}}, e.ready});
                check("busy", {{(9*W-1){1'b0}}, busy}, {{(9*W-1){1'b0}}, e.busy});
                check("kernel_update", {{(9*W-1){1'b0}}, kernel_update}, {{(9*W-1){1'b0}}, e.upd});
                check("kernel_out", kernel_out, e.k);
            end
        end
    end

    initial begin
        act = reset_kernel();
        #12;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Straight load 1..9, correlation order.
        load9(1'b0, 1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (2) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 9; i++) check("direct_tap", W'(kernel_out[i]), W'(i + 1));

        // Flipped load 1..9.
        load9(1'b1, 1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
`ifdef KERNEL_FLIP_EN
        check("flip_tap0", W'(kernel_out[0]), W'(9));
        check("flip_tap8", W'(kernel_out[8]), W'(1));
`else
        check("noflip_tap0", W'(kernel_out[0]), W'(1));
`endif

        // Frame boundary after 5 of 9, plus a restart that discards a same-cycle coefficient.
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, W'(77), 1'b0);
        cyc(1'b1, 1'b0, 1'b1, W'(88), 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, W'(30 + i), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 5; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, W'(30 + i), 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Coefs 10..18 with gaps, then simultaneous load_start and frame_start while armed.
        load9(1'b0, 10, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 9; i++) check("swap_restart_tap", W'(kernel_out[i]), W'(10 + i));
        check("swap_restart_ready", {{(9*W-1){1'b0}}, coef_ready}, {{(9*W-1){1'b0}}, 1'b1});

        // Reset after three accepted coefficients.
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, W'(50 + i), 1'b0);
        do_reset();
        repeat (2) cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) begin
                do_reset();
            end else begin
                cyc(($urandom % 30) == 0, 1'($urandom), ($urandom % 3) != 0,
                    W'($urandom), ($urandom % 6) == 0);
            end
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 153'(exp_q.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kernel_load_ctrl.md
KERNEL_LOAD_CTRL -- requirements
Module: kernel_load_ctrl

Interface
REQ-001 SHALL have parameter: COEF_W, 17, coefficient width in bits.
REQ-002 SHALL have parameter: CENTER_RST, 256, reset value of centre tap 4 (1.0 in Q8).
REQ-003 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: load_start  input  1  single-cycle pulse that begins a 9-coefficient load.
REQ-006 SHALL have port: flip  input  1  1 = convolution order (taps reversed), 0 = correlation order; sampled only with load_start.
REQ-007 SHALL have port: coef_valid  input  1  coefficient present on coef_data.
REQ-008 SHALL have port: coef_data  input  COEF_W  coefficient, raster order tap 0..8.
REQ-009 SHALL have port: coef_ready  output  1  block accepts a coefficient this cycle.
REQ-010 SHALL have port: frame_start  input  1  single-cycle frame-boundary pulse from the pixel pipeline.
REQ-011 SHALL have port: kernel_out  output  9 x COEF_W (packed [8:0][COEF_W-1:0])  active kernel driving the convolution datapath.
REQ-012 SHALL have port: kernel_update  output  1  one-cycle pulse, high in the first cycle new kernel_out is visible.
REQ-013 SHALL have port: busy  output  1  high in LOAD or ARMED.

Function
REQ-014 SHALL hold a 9-entry shadow register bank and a 9-entry active register bank; kernel_out SHALL be the active bank, registered.
REQ-015 SHALL implement states IDLE, LOAD, ARMED; coef_ready = 1 only in LOAD.
REQ-016 IDLE: load_start -> LOAD, index counter idx <= 0, flip_q <= flip; frame_start ignored.
REQ-017 LOAD: each cycle with coef_valid && coef_ready writes coef_data to shadow[flip_q ? 8-idx : idx] and increments idx.
REQ-018 LOAD: acceptance with idx == 8 -> ARMED; idx never exceeds 8, no wrap.
REQ-019 LOAD: frame_start ignored; active bank unchanged.
REQ-020 LOAD: load_start restarts the load (idx <= 0, flip_q recaptured); takes priority over a same-cycle coefficient acceptance, which SHALL be discarded.
REQ-021 ARMED: frame_start copies all 9 shadow entries to the active bank in one edge, pulses kernel_update the next cycle, -> IDLE.
REQ-022 ARMED: load_start without frame_start -> LOAD, shadow contents discarded (not swapped).
REQ-023 ARMED: load_start and frame_start in the same cycle -> swap performed and kernel_update pulsed, state -> LOAD with idx <= 0.
REQ-024 Latency: frame_start sampled at edge N -> kernel_out new and kernel_update high after edge N, for exactly one cycle.
REQ-025 Partially loaded shadow entries SHALL never reach kernel_out.

Reset
REQ-026 rst_n low SHALL asynchronously force: state IDLE, idx 0, flip_q 0, coef_ready 0, kernel_update 0, busy 0.
REQ-027 Reset SHALL set active bank taps 0-3, 5-8 to 0, tap 4 to CENTER_RST; shadow bank to the same values.
REQ-028 Reset mid-LOAD or in ARMED SHALL abandon the load; active bank returns to reset values.

Configuration
REQ-029 Macro KERNEL_FLIP_EN defined: flip honoured per REQ-006/REQ-017.
REQ-030 Macro KERNEL_FLIP_EN undefined: flip ignored, flip_q held 0, all loads in correlation order, no reverse index logic synthesised.

Verification
REQ-031 Reset release, no stimulus -> kernel_out = {0,0,0,0,256,0,0,0,0}, coef_ready 0, busy 0.
REQ-032 load_start flip=0, coefs 1..9 back-to-back, frame_start -> kernel_out[i] = i+1, kernel_update single pulse next cycle.
REQ-033 KERNEL_FLIP_EN defined, load_start flip=1, coefs 1..9 -> kernel_out[0]=9, kernel_out[8]=1; undefined -> kernel_out[0]=1.
REQ-034 frame_start after 5 of 9 coefs -> kernel_out unchanged, no kernel_update; remaining 4 then frame_start -> swap.
REQ-035 Load coefs 10..18 with valid gaps, in ARMED assert load_start and frame_start same cycle -> kernel_out = 10..18, state LOAD, coef_ready 1.
REQ-036 rst_n low after 3 accepted coefs -> immediate IDLE, kernel_out reset values, later frame_start causes no update.
